// File: rtl/hyperbus_pkg.sv
// Shared types and helpers for the HyperBus controller: chip address rules,
// the request-splitter state encoding and a chip-select one-hot helper.
package hyperbus_pkg;

    localparam int unsigned HB_NUM_CHIPS  = 2;
    localparam int unsigned HB_ADDR_WIDTH = 32;
    localparam int unsigned HB_LEN_WIDTH  = 16;
    localparam int unsigned HB_IDX_WIDTH  = (HB_NUM_CHIPS > 1) ? $clog2(HB_NUM_CHIPS) : 1;

    // One address rule per chip. The window is [start_addr, end_addr).
    typedef struct packed {
        logic [31:0]              idx;
        logic [HB_ADDR_WIDTH-1:0] start_addr;
        logic [HB_ADDR_WIDTH-1:0] end_addr;
    } rule_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        ISSUE  = 2'd2,
        ERROR  = 2'd3
    } splitter_state_e;

    // One-hot chip select for chip idx; indices at or above num_chips give all-zero.
    function automatic logic [HB_NUM_CHIPS-1:0] onehot_chip(
        input logic [HB_IDX_WIDTH-1:0] idx,
        input int unsigned             num_chips
    );
        logic [HB_NUM_CHIPS-1:0] oh;
        oh = '0;
        for (int unsigned i = 0; i < HB_NUM_CHIPS; i++) begin
            if ((i < num_chips) && (idx == HB_IDX_WIDTH'(i))) begin
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/hyperbus_rule_match.sv
// Combinational priority matcher: finds the lowest-index chip whose rule
// window contains the given address. Empty or inverted windows never match.
module hyperbus_rule_match
    import hyperbus_pkg::*;
(
    input  rule_t [HB_NUM_CHIPS-1:0]  i_rules,
    input  logic [HB_ADDR_WIDTH-1:0]  i_addr,
    output logic                      o_match,
    output logic [HB_IDX_WIDTH-1:0]   o_idx,
    output logic [HB_ADDR_WIDTH-1:0]  o_start,
    output logic [HB_ADDR_WIDTH-1:0]  o_end
);

    logic w_unused_idx;

    // Scan from the highest index down so the lowest matching index wins.
    always_comb begin
        o_match = 1'b0;
        o_idx   = '0;
        o_start = '0;
        o_end   = '0;
        for (int i = int'(HB_NUM_CHIPS) - 1; i >= 0; i--) begin
            if ((i_rules[i].end_addr > i_rules[i].start_addr) &&
                (i_addr >= i_rules[i].start_addr) &&
                (i_addr <  i_rules[i].end_addr)) begin
                o_match = 1'b1;
                o_idx   = HB_IDX_WIDTH'(i);
                o_start = i_rules[i].start_addr;
                o_end   = i_rules[i].end_addr;
            end
        end
    end

    // The idx field mirrors array position in the config file; decode goes by position.
    always_comb begin
        w_unused_idx = 1'b0;
        for (int i = 0; i < int'(HB_NUM_CHIPS); i++) begin
            w_unused_idx = w_unused_idx ^ (^i_rules[i].idx);
        end
    end

endmodule

// File: rtl/hyperbus_chip_splitter.sv
// Splits a linear transfer request into per-chip sub-transfers, converting to
// chip-relative addresses and flagging unmapped, zero-length or wrapping requests.
// Handshakes: a transfer moves on a cycle where valid and ready are both high;
// valid is never withdrawn and its payload is held stable until that cycle.
module hyperbus_chip_splitter
    import hyperbus_pkg::*;
(
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  rule_t [HB_NUM_CHIPS-1:0]      chip_rules_i,
    input  logic                          trans_valid_i,
    output logic                          trans_ready_o,
    input  logic [HB_ADDR_WIDTH-1:0]      trans_addr_i,
    input  logic [HB_LEN_WIDTH-1:0]       trans_len_i,
    input  logic                          trans_write_i,
    output logic                          sub_valid_o,
    input  logic                          sub_ready_i,
    output logic [HB_ADDR_WIDTH-1:0]      sub_addr_o,
    output logic [HB_LEN_WIDTH-1:0]       sub_len_o,
    output logic                          sub_write_o,
    output logic [HB_NUM_CHIPS-1:0]       sub_cs_o,
    output logic                          sub_last_o,
    output logic                          err_o,
    output logic [HB_ADDR_WIDTH-1:0]      err_addr_o,
    output logic                          trans_active_o
);

    localparam int unsigned AW = HB_ADDR_WIDTH;
    localparam int unsigned LW = HB_LEN_WIDTH;
    localparam int unsigned NC = HB_NUM_CHIPS;

    splitter_state_e   r_state;
    logic [AW-1:0]     r_addr;
    logic [LW-1:0]     r_remaining;
    logic              r_write;
    rule_t [NC-1:0]    r_rules;

    logic              r_trans_ready;
    logic              r_sub_valid;
    logic [AW-1:0]     r_sub_addr;
    logic [LW-1:0]     r_sub_len;
    logic              r_sub_write;
    logic [NC-1:0]     r_sub_cs;
    logic              r_sub_last;
    logic              r_err;
    logic [AW-1:0]     r_err_addr;
    logic              r_active;

    logic                    w_match;
    logic [HB_IDX_WIDTH-1:0] w_idx;
    logic [AW-1:0]           w_start;
    logic [AW-1:0]           w_end;
    logic [AW-1:0]           w_span;
    logic [LW-1:0]           w_span_sat;
    logic [LW-1:0]           w_sub_len;
    logic [AW:0]             w_sum;

    hyperbus_rule_match u_rule_match (
        .i_rules (r_rules),
        .i_addr  (r_addr),
        .o_match (w_match),
        .o_idx   (w_idx),
        .o_start (w_start),
        .o_end   (w_end)
    );

    // Bytes left in the matched chip, clamped to what a length field can carry.
    assign w_span     = w_end - r_addr;
    assign w_span_sat = (|w_span[AW-1:LW]) ? {LW{1'b1}} : w_span[LW-1:0];
    assign w_sub_len  = (r_remaining < w_span_sat) ? r_remaining : w_span_sat;
    // Extra top bit catches an address that wraps past the end of the space.
    assign w_sum      = {1'b0, r_addr} + {{(AW - LW + 1){1'b0}}, r_sub_len};

    // Splitter FSM with all outputs registered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= IDLE;
            r_addr        <= '0;
            r_remaining   <= '0;
            r_write       <= 1'b0;
            r_rules       <= '0;
            r_trans_ready <= 1'b1;
            r_sub_valid   <= 1'b0;
            r_sub_addr    <= '0;
            r_sub_len     <= '0;
            r_sub_write   <= 1'b0;
            r_sub_cs      <= '0;
            r_sub_last    <= 1'b0;
            r_err         <= 1'b0;
            r_err_addr    <= '0;
            r_active      <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (trans_valid_i && r_trans_ready) begin
                        r_addr        <= trans_addr_i;
                        r_remaining   <= trans_len_i;
                        r_write       <= trans_write_i;
                        r_rules       <= chip_rules_i;
                        r_trans_ready <= 1'b0;
                        r_active      <= 1'b1;
                        r_state       <= DECODE;
                    end else begin
                        // Ready comes back one cycle after re-entering IDLE.
                        r_trans_ready <= 1'b1;
                    end
                end
                DECODE: begin
                    if ((r_remaining == '0) || !w_match) begin
                        r_err      <= 1'b1;
                        r_err_addr <= r_addr;
                        r_state    <= ERROR;
                    end else begin
                        r_sub_cs    <= onehot_chip(w_idx, NC);
                        r_sub_addr  <= r_addr - w_start;
                        r_sub_len   <= w_sub_len;
                        r_sub_last  <= (w_sub_len == r_remaining);
                        r_sub_write <= r_write;
                        r_sub_valid <= 1'b1;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (sub_ready_i) begin
                        r_sub_valid <= 1'b0;
                        r_addr      <= w_sum[AW-1:0];
                        r_remaining <= r_remaining - r_sub_len;
                        if (r_sub_last) begin
                            r_active <= 1'b0;
                            r_state  <= IDLE;
                        end else if (w_sum[AW]) begin
                            r_err      <= 1'b1;
                            r_err_addr <= w_sum[AW-1:0];
                            r_state    <= ERROR;
                        end else begin
                            r_state <= DECODE;
                        end
                    end
                end
                ERROR: begin
                    r_active <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign trans_ready_o  = r_trans_ready;
    assign sub_valid_o    = r_sub_valid;
    assign sub_addr_o     = r_sub_addr;
    assign sub_len_o      = r_sub_len;
    assign sub_write_o    = r_sub_write;
    assign sub_cs_o       = r_sub_cs;
    assign sub_last_o     = r_sub_last;
    assign err_o          = r_err;
    assign err_addr_o     = r_err_addr;
    assign trans_active_o = r_active;

endmodule

// File: tb/tb_hyperbus_chip_splitter.sv
// Directed bench for hyperbus_chip_splitter: latency, splitting, errors,
// backpressure with a rules change, and asynchronous reset mid-transfer.
module tb_hyperbus_chip_splitter;
  import hyperbus_pkg::*;

  localparam int SUB_W = 2 + 32 + 16 + 1 + 1;

  logic             clk_i;
  logic             rst_ni;
  rule_t [1:0]      chip_rules_i;
  logic             trans_valid_i;
  logic             trans_ready_o;
  logic [31:0]      trans_addr_i;
  logic [15:0]      trans_len_i;
  logic             trans_write_i;
  logic             sub_valid_o;
  logic             sub_ready_i;
  logic [31:0]      sub_addr_o;
  logic [15:0]      sub_len_o;
  logic             sub_write_o;
  logic [1:0]       sub_cs_o;
  logic             sub_last_o;
  logic             err_o;
  logic [31:0]      err_addr_o;
  logic             trans_active_o;

  logic [SUB_W-1:0] exp_q[$];
  logic [31:0]      err_q[$];
  int               n_cmp;
  int               n_err;

  hyperbus_chip_splitter dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .chip_rules_i   (chip_rules_i),
    .trans_valid_i  (trans_valid_i),
    .trans_ready_o  (trans_ready_o),
    .trans_addr_i   (trans_addr_i),
    .trans_len_i    (trans_len_i),
    .trans_write_i  (trans_write_i),
    .sub_valid_o    (sub_valid_o),
    .sub_ready_i    (sub_ready_i),
    .sub_addr_o     (sub_addr_o),
    .sub_len_o      (sub_len_o),
    .sub_write_o    (sub_write_o),
    .sub_cs_o       (sub_cs_o),
    .sub_last_o     (sub_last_o),
    .err_o          (err_o),
    .err_addr_o     (err_addr_o),
    .trans_active_o (trans_active_o)
  );

  // ---------------- clock / reset ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [SUB_W-1:0] mk_sub(input logic [1:0] cs, input logic [31:0] addr,
                                              input logic [15:0] len, input logic wr, input logic last);
    return {cs, addr, len, wr, last};
  endfunction

  function automatic rule_t mk_rule(input logic [31:0] idx, input logic [31:0] s, input logic [31:0] e);
    rule_t r;
    r.idx        = idx;
    r.start_addr = s;
    r.end_addr   = e;
    return r;
  endfunction

  // Scoreboard: every sub-transfer handshake pops one expected payload.
  always @(negedge clk_i) begin
    if (rst_ni && sub_valid_o && sub_ready_i) begin
      if (exp_q.size() == 0) check("sub_unexpected", 64'(sub_addr_o), 64'hFFFF_FFFF_FFFF_FFFF);
      else check("sub_payload", 64'({sub_cs_o, sub_addr_o, sub_len_o, sub_write_o, sub_last_o}),
                 64'(exp_q.pop_front()));
    end
    if (rst_ni && err_o) begin
      if (err_q.size() == 0) check("err_unexpected", 64'(err_addr_o), 64'hFFFF_FFFF_FFFF_FFFF);
      else check("err_addr_q", 64'(err_addr_o), 64'(err_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_ready(input int bound);
    int k;
    k = 0;
    while (!trans_ready_o && k < bound) begin
      step();
      k++;
    end
    if (!trans_ready_o) check("ready_timeout", 64'(trans_ready_o), 64'd1);
  endtask

  // Returns in cycle N+1, where N is the accept cycle.
  task automatic send(input logic [31:0] addr, input logic [15:0] len, input logic wr);
    wait_ready(50);
    trans_addr_i  = addr;
    trans_len_i   = len;
    trans_write_i = wr;
    trans_valid_i = 1'b1;
    step();
    trans_valid_i = 1'b0;
  endtask

  task automatic run_req(input logic [31:0] addr, input logic [15:0] len, input logic wr);
    send(addr, len, wr);
    sub_ready_i = 1'b1;
    step();
    wait_ready(50);
    sub_ready_i = 1'b0;
  endtask

  task automatic set_default_rules();
    chip_rules_i[0] = mk_rule(32'd0, 32'h0000_0000, 32'h0001_0000);
    chip_rules_i[1] = mk_rule(32'd1, 32'h0001_0000, 32'h0002_0000);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_ni        = 1'b0;
    trans_valid_i = 1'b0;
    trans_addr_i  = '0;
    trans_len_i   = '0;
    trans_write_i = 1'b0;
    sub_ready_i   = 1'b0;
    set_default_rules();

    // Reset state
    step();
    step();
    check("rst_ready",   64'(trans_ready_o), 64'd1);
    check("rst_valid",   64'(sub_valid_o), 64'd0);
    check("rst_active",  64'(trans_active_o), 64'd0);
    check("rst_err",     64'(err_o), 64'd0);
    check("rst_payload", 64'({sub_cs_o, sub_addr_o, sub_len_o, sub_last_o, sub_write_o}), 64'd0);
    rst_ni = 1'b1;
    step();

    // Single chip with latency and active window
    exp_q.push_back(mk_sub(2'b01, 32'h100, 16'h40, 1'b0, 1'b1));
    send(32'h100, 16'h40, 1'b0);
    check("t1_active_n1", 64'(trans_active_o), 64'd1);
    check("t1_valid_n1",  64'(sub_valid_o), 64'd0);
    check("t1_ready_n1",  64'(trans_ready_o), 64'd0);
    step();
    check("t1_valid_n2",  64'(sub_valid_o), 64'd1);
    check("t1_active_n2", 64'(trans_active_o), 64'd1);
    sub_ready_i = 1'b1;
    step();
    sub_ready_i = 1'b0;
    check("t1_valid_n3",  64'(sub_valid_o), 64'd0);
    check("t1_active_n3", 64'(trans_active_o), 64'd0);
    check("t1_ready_n3",  64'(trans_ready_o), 64'd0);
    step();
    check("t1_ready_n4",  64'(trans_ready_o), 64'd1);

    // Boundary split with inter-sub latency
    exp_q.push_back(mk_sub(2'b01, 32'hFFF0, 16'h10, 1'b1, 1'b0));
    exp_q.push_back(mk_sub(2'b10, 32'h0,    16'h10, 1'b1, 1'b1));
    send(32'hFFF0, 16'h20, 1'b1);
    step();
    check("t2_valid_s0", 64'(sub_valid_o), 64'd1);
    sub_ready_i = 1'b1;
    step();
    check("t2_gap", 64'(sub_valid_o), 64'd0);
    step();
    check("t2_valid_s1", 64'(sub_valid_o), 64'd1);
    step();
    check("t2_done", 64'(sub_valid_o), 64'd0);
    sub_ready_i = 1'b0;
    wait_ready(50);

    // Unmapped address
    err_q.push_back(32'h3_0000);
    send(32'h3_0000, 16'd4, 1'b0);
    step();
    check("t3_err_pulse", 64'(err_o), 64'd1);
    check("t3_err_addr",  64'(err_addr_o), 64'h3_0000);
    check("t3_no_valid",  64'(sub_valid_o), 64'd0);
    check("t3_active",    64'(trans_active_o), 64'd1);
    step();
    check("t3_err_drop",  64'(err_o), 64'd0);
    check("t3_err_hold",  64'(err_addr_o), 64'h3_0000);
    check("t3_inactive",  64'(trans_active_o), 64'd0);
    wait_ready(50);

    // Zero length
    err_q.push_back(32'h100);
    run_req(32'h100, 16'd0, 1'b0);
    check("t4_err_addr", 64'(err_addr_o), 64'h100);

    // Tail past the last chip
    exp_q.push_back(mk_sub(2'b10, 32'hFFF8, 16'h8, 1'b0, 1'b0));
    err_q.push_back(32'h2_0000);
    run_req(32'h1_FFF8, 16'h10, 1'b0);
    check("t5_err_addr", 64'(err_addr_o), 64'h2_0000);

    // Backpressure, rules change mid-request, stray request during ISSUE
    exp_q.push_back(mk_sub(2'b01, 32'hFFF0, 16'h10, 1'b1, 1'b0));
    exp_q.push_back(mk_sub(2'b10, 32'h0,    16'h10, 1'b1, 1'b1));
    send(32'hFFF0, 16'h20, 1'b1);
    chip_rules_i[0] = mk_rule(32'd0, 32'h0000_0000, 32'h0000_8000);
    chip_rules_i[1] = mk_rule(32'd1, 32'h0000_8000, 32'h0003_0000);
    step();
    for (int i = 0; i < 5; i++) begin
      check("t6_hold_payload", 64'({sub_valid_o, sub_cs_o, sub_addr_o, sub_len_o, sub_last_o}),
            64'({1'b1, 2'b01, 32'hFFF0, 16'h10, 1'b0}));
      if (i == 2) begin
        trans_addr_i  = 32'h200;
        trans_len_i   = 16'd4;
        trans_valid_i = 1'b1;
      end else begin
        trans_valid_i = 1'b0;
      end
      step();
    end
    trans_valid_i = 1'b0;
    sub_ready_i = 1'b1;
    step();
    wait_ready(50);
    sub_ready_i = 1'b0;
    step();
    check("t6_stray_ignored", 64'(trans_active_o), 64'd0);
    check("t6_ready_idle",    64'(trans_ready_o), 64'd1);
    set_default_rules();

    // Asynchronous reset during ISSUE
    send(32'h100, 16'h40, 1'b0);
    step();
    check("t7_valid_pre", 64'(sub_valid_o), 64'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("t7_rst_valid",   64'(sub_valid_o), 64'd0);
    check("t7_rst_ready",   64'(trans_ready_o), 64'd1);
    check("t7_rst_active",  64'(trans_active_o), 64'd0);
    check("t7_rst_payload", 64'({sub_cs_o, sub_addr_o, sub_len_o, sub_last_o, sub_write_o}), 64'd0);
    check("t7_rst_err",     64'({err_o, err_addr_o}), 64'd0);
    step();
    rst_ni = 1'b1;
    step();
    exp_q.push_back(mk_sub(2'b10, 32'h10, 16'h8, 1'b0, 1'b1));
    run_req(32'h1_0010, 16'h8, 1'b0);

    // Final report
    step();
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("err_q_drained", 64'(err_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
